morra_cinese: RTL and testbench



---
 rtl/morra_cinese_pkg.sv | 36 +++
 rtl/morra_cinese_judge.sv | 27 ++
 rtl/morra_cinese.sv | 110 +++++++++++
 tb/tb_morra_cinese.sv | 123 ++++++++++++
 4 files changed

// File: rtl/morra_cinese_pkg.sv
// Shared types and constants for the Morra Cinese referee.
package morra_cinese_pkg;

    typedef enum logic [1:0] {
        MV_NONE     = 2'b00,
        MV_ROCK     = 2'b01,
        MV_PAPER    = 2'b10,
        MV_SCISSORS = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_DRAW = 2'b11
    } result_t;

    // 00 means "invalid" on the round output and "ongoing" on the game output
    localparam result_t RES_INVALID = RES_NONE;
    localparam result_t RES_ONGOING = RES_NONE;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    typedef struct packed {
        logic  valid;
        logic  is_p2;
        move_t mv;
    } last_win_t;

    localparam int MIN_ROUNDS  = 4;
    localparam int BASE_ROUNDS = 4;

endpackage

// File: rtl/morra_cinese_judge.sv
// Combinational rock-paper-scissors judge; ignores the repeat-move rule.
module morra_judge
    import morra_cinese_pkg::*;
(
    input  move_t   mv1,
    input  move_t   mv2,
    output result_t res
);

    logic p1_beats_p2;

    always_comb begin
        p1_beats_p2 = ((mv1 == MV_ROCK)     && (mv2 == MV_SCISSORS)) ||
                      ((mv1 == MV_SCISSORS) && (mv2 == MV_PAPER))    ||
                      ((mv1 == MV_PAPER)    && (mv2 == MV_ROCK));
        if ((mv1 == MV_NONE) || (mv2 == MV_NONE)) begin
            res = RES_INVALID;
        end else if (mv1 == mv2) begin
            res = RES_DRAW;
        end else if (p1_beats_p2) begin
            res = RES_P1;
        end else begin
            res = RES_P2;
        end
    end

endmodule

// File: rtl/morra_cinese.sv
// Morra Cinese referee: judges each round, keeps score and declares the game result.
module morra_cinese
    import morra_cinese_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] p1,
    input  logic [1:0] p2,
    input  logic       start,
    output logic [1:0] round,
    output logic [1:0] game
);

    state_t           state_q, state_d;
    logic [4:0]       max_rounds_q, max_rounds_d;
    logic [4:0]       played_q, played_d;
    logic signed [5:0] diff_q, diff_d;
    last_win_t        last_win_q, last_win_d;
    result_t          round_q, round_d;
    result_t          game_q, game_d;

    move_t   p1_mv, p2_mv;
    result_t judged;
    logic    repeat_move;

    assign p1_mv = move_t'(p1);
    assign p2_mv = move_t'(p2);

    morra_judge u_judge (
        .mv1 (p1_mv),
        .mv2 (p2_mv),
        .res (judged)
    );

    // Only the previous winner is constrained, and only against its own winning move
    assign repeat_move = last_win_q.valid &&
                         (last_win_q.is_p2 ? (p2_mv == last_win_q.mv)
                                           : (p1_mv == last_win_q.mv));

    always_comb begin
        state_d      = state_q;
        max_rounds_d = max_rounds_q;
        played_d     = played_q;
        diff_d       = diff_q;
        last_win_d   = last_win_q;
        round_d      = RES_INVALID;
        game_d       = RES_ONGOING;

        if (start) begin
            max_rounds_d = 5'(BASE_ROUNDS) + {1'b0, p1, p2};
            played_d     = '0;
            diff_d       = '0;
            last_win_d   = '0;
            state_d      = ST_PLAY;
        end else if ((state_q == ST_PLAY) && (judged != RES_INVALID) && !repeat_move) begin
            played_d = played_q + 5'd1;
            round_d  = judged;
            case (judged)
                RES_P1: begin
                    diff_d     = diff_q + 6'sd1;
                    last_win_d = '{valid: 1'b1, is_p2: 1'b0, mv: p1_mv};
                end
                RES_P2: begin
                    diff_d     = diff_q - 6'sd1;
                    last_win_d = '{valid: 1'b1, is_p2: 1'b1, mv: p2_mv};
                end
                default: begin
                    last_win_d = '0;
                end
            endcase

            // End check uses the freshly updated score so the result lands with the round
            if (((played_d >= 5'(MIN_ROUNDS)) && ((diff_d >= 6'sd2) || (diff_d <= -6'sd2))) ||
                (played_d == max_rounds_q)) begin
                if (diff_d > 6'sd0) begin
                    game_d = RES_P1;
                end else if (diff_d < 6'sd0) begin
                    game_d = RES_P2;
                end else begin
                    game_d = RES_DRAW;
                end
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            max_rounds_q <= '0;
            played_q     <= '0;
            diff_q       <= '0;
            last_win_q   <= '0;
            round_q      <= RES_INVALID;
            game_q       <= RES_ONGOING;
        end else begin
            state_q      <= state_d;
            max_rounds_q <= max_rounds_d;
            played_q     <= played_d;
            diff_q       <= diff_d;
            last_win_q   <= last_win_d;
            round_q      <= round_d;
            game_q       <= game_d;
        end
    end

    assign round = round_q;
    assign game  = game_q;

endmodule

// File: tb/tb_morra_cinese.sv
// Directed self-checking bench for morra_cinese with hand-computed round/game values.
module tb_morra_cinese;

    logic       clk;
    logic       rst_n;
    logic [1:0] p1;
    logic [1:0] p2;
    logic       start;
    logic [1:0] round;
    logic [1:0] game;

    int testCount;
    int failCount;

    morra_cinese dut (
        .clk   (clk),
        .rst_n (rst_n),
        .p1    (p1),
        .p2    (p2),
        .start (start),
        .round (round),
        .game  (game)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: round/game got %b/%b, expected %b/%b",
                     tag, observed[3:2], observed[1:0], expected[3:2], expected[1:0]);
        end
    endtask

    // Drives one cycle of inputs, samples 1 time unit after the edge, then checks.
    task automatic applyStimulus(input string tag, input logic st, input logic [1:0] m1,
                                 input logic [1:0] m2, input logic [1:0] expRound,
                                 input logic [1:0] expGame);
        start = st;
        p1    = m1;
        p2    = m2;
        @(posedge clk);
        #1;
        checkOutput(tag, {round, game}, {expRound, expGame});
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst_n = 1'b0;
        start = 1'b0;
        p1    = 2'b00;
        p2    = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", {round, game}, 4'b0000);
        #2 rst_n = 1'b1;

        // Game 1: max 4, four counted draws end in a draw
        applyStimulus("g1 start",    1, 2'b00, 2'b00, 2'b00, 2'b00);
        applyStimulus("g1 draw1",    0, 2'b01, 2'b01, 2'b11, 2'b00);
        applyStimulus("g1 draw2",    0, 2'b10, 2'b10, 2'b11, 2'b00);
        applyStimulus("g1 draw3",    0, 2'b11, 2'b11, 2'b11, 2'b00);
        applyStimulus("g1 none",     0, 2'b00, 2'b00, 2'b00, 2'b00);
        applyStimulus("g1 draw4",    0, 2'b01, 2'b01, 2'b11, 2'b11);
        applyStimulus("g1 idle",     0, 2'b01, 2'b10, 2'b00, 2'b00);

        // Game 2: two start cycles, last config wins (max 5)
        applyStimulus("g2 start0",   1, 2'b00, 2'b00, 2'b00, 2'b00);
        applyStimulus("g2 start1",   1, 2'b00, 2'b01, 2'b00, 2'b00);
        applyStimulus("g2 p2win",    0, 2'b01, 2'b10, 2'b10, 2'b00);
        applyStimulus("g2 p1win a",  0, 2'b01, 2'b11, 2'b01, 2'b00);
        applyStimulus("g2 p1win b",  0, 2'b10, 2'b01, 2'b01, 2'b00);
        applyStimulus("g2 draw",     0, 2'b11, 2'b11, 2'b11, 2'b00);
        applyStimulus("g2 invalid",  0, 2'b11, 2'b00, 2'b00, 2'b00);
        applyStimulus("g2 final",    0, 2'b10, 2'b01, 2'b01, 2'b01);

        // Game 3: lead of 2 is not enough before 4 rounds
        applyStimulus("g3 start",    1, 2'b00, 2'b01, 2'b00, 2'b00);
        applyStimulus("g3 draw",     0, 2'b01, 2'b01, 2'b11, 2'b00);
        applyStimulus("g3 p1win a",  0, 2'b01, 2'b11, 2'b01, 2'b00);
        applyStimulus("g3 p1win b",  0, 2'b10, 2'b01, 2'b01, 2'b00);
        applyStimulus("g3 draw end", 0, 2'b11, 2'b11, 2'b11, 2'b01);
        applyStimulus("g3 idle a",   0, 2'b11, 2'b00, 2'b00, 2'b00);
        applyStimulus("g3 idle b",   0, 2'b10, 2'b01, 2'b00, 2'b00);

        // Game 4: repeat-move rule and max-rounds end (max 6)
        applyStimulus("g4 start",    1, 2'b00, 2'b10, 2'b00, 2'b00);
        applyStimulus("g4 draw",     0, 2'b01, 2'b01, 2'b11, 2'b00);
        applyStimulus("g4 p1win",    0, 2'b11, 2'b10, 2'b01, 2'b00);
        applyStimulus("g4 repeat",   0, 2'b11, 2'b10, 2'b00, 2'b00);
        applyStimulus("g4 p2win",    0, 2'b10, 2'b11, 2'b10, 2'b00);
        applyStimulus("g4 draw2",    0, 2'b01, 2'b01, 2'b11, 2'b00);
        applyStimulus("g4 draw3",    0, 2'b01, 2'b01, 2'b11, 2'b00);
        applyStimulus("g4 final",    0, 2'b01, 2'b10, 2'b10, 2'b10);

        // Async reset mid-game clears outputs without a clock edge
        applyStimulus("g5 start",    1, 2'b00, 2'b00, 2'b00, 2'b00);
        applyStimulus("g5 draw",     0, 2'b01, 2'b01, 2'b11, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("g5 async rst", {round, game}, 4'b0000);
        #1 rst_n = 1'b1;
        applyStimulus("g5 post rst", 0, 2'b01, 2'b10, 2'b00, 2'b00);

        // Start mid-game aborts and clears the counters
        applyStimulus("g6 start",    1, 2'b00, 2'b00, 2'b00, 2'b00);
        applyStimulus("g6 draw1",    0, 2'b01, 2'b01, 2'b11, 2'b00);
        applyStimulus("g6 draw2",    0, 2'b10, 2'b10, 2'b11, 2'b00);
        applyStimulus("g6 restart",  1, 2'b00, 2'b00, 2'b00, 2'b00);
        applyStimulus("g6 draw3",    0, 2'b01, 2'b01, 2'b11, 2'b00);
        applyStimulus("g6 draw4",    0, 2'b10, 2'b10, 2'b11, 2'b00);
        applyStimulus("g6 draw5",    0, 2'b11, 2'b11, 2'b11, 2'b00);
        applyStimulus("g6 draw6",    0, 2'b01, 2'b01, 2'b11, 2'b11);
        applyStimulus("g6 idle",     0, 2'b01, 2'b01, 2'b00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
